// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: sequences pad power-up/down (ENABLE_H, HLD_H_N),
// holds drive configuration in shadow registers, forces safe input-only
// settings outside ACTIVE, and synchronizes and debounces the pad input.
// Ports:
//   clk, rst_n                       core clock, async active-low reset
//   pad_en                           1 requests power-up, 0 power-down
//   cfg_we, cfg_dm, cfg_inp_dis,     configuration write into shadow regs
//   cfg_slow
//   dout, doe                        core data / output enable to pad
//   din, din_rise, din_fall          debounced input and edge pulses
//   ready                            high in ACTIVE only
//   OUT, OE_N, DM, INP_DIS, SLOW,    pad-side controls
//   HLD_H_N, ENABLE_H, ENABLE_INP_H
//   IN                               raw pad input, asynchronous to clk
module gpio_pad_ctrl #(
    parameter int unsigned PWRUP_CYCLES    = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pad_en,
    input  logic       cfg_we,
    input  logic [2:0] cfg_dm,
    input  logic       cfg_inp_dis,
    input  logic       cfg_slow,
    input  logic       dout,
    input  logic       doe,
    output logic       din,
    output logic       din_rise,
    output logic       din_fall,
    output logic       ready,
    output logic       OUT,
    output logic       OE_N,
    output logic [2:0] DM,
    output logic       INP_DIS,
    output logic       SLOW,
    output logic       HLD_H_N,
    output logic       ENABLE_H,
    output logic       ENABLE_INP_H,
    input  logic       IN
);

    localparam int unsigned     CNT_W      = 8;
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_TGT    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [2:0]       DM_SAFE    = 3'b001;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        SETTLE  = 3'd1,
        RELEASE = 3'd2,
        ACTIVE  = 3'd3,
        HOLD_DN = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] dcnt_inc;
    logic [2:0]       sh_dm_q, sh_dm_d;
    logic             sh_inp_dis_q, sh_inp_dis_d;
    logic             sh_slow_q, sh_slow_d;
    logic             in_s1_q, in_s2_q;
    logic             din_dly_q;
    logic             frozen;

    logic             din_d, rise_d, fall_d, ready_d, out_d, oe_n_d;
    logic [2:0]       dm_d;
    logic             inp_dis_d, slow_d, hld_d, en_d;

    // State, counters, shadow config and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= OFF;
            pcnt_q       <= '0;
            dcnt_q       <= '0;
            sh_dm_q      <= DM_SAFE;
            sh_inp_dis_q <= 1'b0;
            sh_slow_q    <= 1'b0;
            in_s1_q      <= 1'b0;
            in_s2_q      <= 1'b0;
            din_dly_q    <= 1'b0;
            din          <= 1'b0;
            din_rise     <= 1'b0;
            din_fall     <= 1'b0;
            ready        <= 1'b0;
            OUT          <= 1'b0;
            OE_N         <= 1'b1;
            DM           <= DM_SAFE;
            INP_DIS      <= 1'b0;
            SLOW         <= 1'b0;
            HLD_H_N      <= 1'b0;
            ENABLE_H     <= 1'b0;
            ENABLE_INP_H <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            dcnt_q       <= dcnt_d;
            sh_dm_q      <= sh_dm_d;
            sh_inp_dis_q <= sh_inp_dis_d;
            sh_slow_q    <= sh_slow_d;
            in_s1_q      <= IN;
            in_s2_q      <= in_s1_q;
            din_dly_q    <= din;
            din          <= din_d;
            din_rise     <= rise_d;
            din_fall     <= fall_d;
            ready        <= ready_d;
            OUT          <= out_d;
            OE_N         <= oe_n_d;
            DM           <= dm_d;
            INP_DIS      <= inp_dis_d;
            SLOW         <= slow_d;
            HLD_H_N      <= hld_d;
            ENABLE_H     <= en_d;
            ENABLE_INP_H <= en_d;
        end
    end

    // Next state, counters and output decode from the next state so pad
    // controls change in the same cycle as the state they belong to
    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        sh_dm_d      = sh_dm_q;
        sh_inp_dis_d = sh_inp_dis_q;
        sh_slow_d    = sh_slow_q;
        dcnt_d       = '0;
        dcnt_inc     = '0;
        din_d        = din;
        rise_d       = 1'b0;
        fall_d       = 1'b0;

        unique case (state_q)
            OFF: begin
                pcnt_d = '0;
                if (pad_en) state_d = SETTLE;
            end
            SETTLE: begin
                if (!pad_en) begin
                    state_d = OFF;
                    pcnt_d  = '0;
                end else if (pcnt_q >= PWRUP_LAST) begin
                    state_d = RELEASE;
                    pcnt_d  = '0;
                end else if (pcnt_q != CNT_MAX) begin
                    pcnt_d = pcnt_q + CNT_W'(1);
                end
            end
            RELEASE: state_d = ACTIVE;
            ACTIVE:  if (!pad_en) state_d = HOLD_DN;
            HOLD_DN: state_d = OFF;
            default: state_d = OFF;
        endcase

        if (cfg_we) begin
            sh_dm_d      = cfg_dm;
            sh_inp_dis_d = cfg_inp_dis;
            sh_slow_d    = cfg_slow;
        end

        // Debouncer: count consecutive disagreeing samples, frozen when the
        // input buffer is disabled or the pad is not fully powered
        frozen = (state_q != ACTIVE) || INP_DIS;
        if (!frozen) begin
            if (in_s2_q != din) begin
                dcnt_inc = (dcnt_q == CNT_MAX) ? dcnt_q : dcnt_q + CNT_W'(1);
                if (dcnt_inc >= DEB_TGT) begin
                    din_d  = in_s2_q;
                    dcnt_d = '0;
                end else begin
                    dcnt_d = dcnt_inc;
                end
            end
            rise_d = din & ~din_dly_q;
            fall_d = ~din & din_dly_q;
        end

        ready_d   = (state_d == ACTIVE);
        out_d     = ready_d & dout;
        oe_n_d    = ~(ready_d & doe);
        dm_d      = ready_d ? sh_dm_d : DM_SAFE;
        inp_dis_d = ready_d & sh_inp_dis_d;
        slow_d    = ready_d & sh_slow_d;
        hld_d     = (state_d == RELEASE) || (state_d == ACTIVE);
        en_d      = (state_d != OFF);
    end

endmodule

// File: doc/gpio_pad_ctrl.md
GPIO_PAD_CTRL -- requirements
Module: gpio_pad_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- PWRUP_CYCLES, 16, settle cycles between ENABLE_H assertion and hold release (range 1..255).
- DEBOUNCE_CYCLES, 4, stable-input cycles required before din updates (range 1..255).
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, core clock.
- rst_n, in, 1, reset; asynchronous assert, active-low.
- pad_en, in, 1, request pad power-up; 0 requests power-down.
- cfg_we, in, 1, configuration write strobe.
- cfg_dm, in, 3, requested drive mode.
- cfg_inp_dis, in, 1, requested input disable.
- cfg_slow, in, 1, requested slow slew.
- dout, in, 1, core data to pad.
- doe, in, 1, core output enable, active-high.
- din, out, 1, debounced pad input.
- din_rise, out, 1, one-cycle pulse on debounced rising edge.
- din_fall, out, 1, one-cycle pulse on debounced falling edge.
- ready, out, 1, high in ACTIVE only.
- OUT, out, 1, to pad OUT.
- OE_N, out, 1, to pad OE_N.
- DM, out, 3, to pad DM.
- INP_DIS, out, 1, to pad INP_DIS.
- SLOW, out, 1, to pad SLOW.
- HLD_H_N, out, 1, to pad HLD_H_N.
- ENABLE_H, out, 1, to pad ENABLE_H.
- ENABLE_INP_H, out, 1, to pad ENABLE_INP_H.
- IN, in, 1, from pad IN; asynchronous to clk.
REQ-003 Clock SHALL be clk and reset rst_n; one clock domain, reset asynchronous active-low.

Function
REQ-004 The FSM SHALL have states OFF, SETTLE, RELEASE, ACTIVE, HOLD_DN.
REQ-005 OFF->SETTLE SHALL occur when pad_en=1; ENABLE_H=1 and ENABLE_INP_H=1 from the cycle SETTLE is entered.
REQ-006 SETTLE SHALL count PWRUP_CYCLES cycles, then go to RELEASE; pad_en=0 during SETTLE SHALL return to OFF next cycle and clear the counter.
REQ-007 RELEASE SHALL last exactly 1 cycle with HLD_H_N=1, then go to ACTIVE.
REQ-008 ACTIVE->HOLD_DN SHALL occur on pad_en=0; HOLD_DN drives HLD_H_N=0 for 1 cycle, then goes to OFF with ENABLE_H=0 and ENABLE_INP_H=0.
REQ-009 HLD_H_N SHALL be 1 only in RELEASE and ACTIVE.
REQ-010 A cfg_we=1 cycle SHALL capture cfg_dm, cfg_inp_dis and cfg_slow into shadow registers in any state; the last write wins.
REQ-011 In ACTIVE, DM, INP_DIS and SLOW SHALL equal the shadow values one cycle after capture; outside ACTIVE they SHALL be 3'b001, 0 and 0 (safe input-only).
REQ-012 OUT SHALL be dout registered, and OE_N SHALL be ~doe registered (1-cycle latency), in ACTIVE only; otherwise OUT=0 and OE_N=1.
REQ-013 IN SHALL pass a 2-flop synchronizer; the debouncer counts consecutive cycles where the synced value differs from din, resets the count on agreement, and updates din when the count reaches DEBOUNCE_CYCLES.
REQ-014 din_rise/din_fall SHALL pulse for 1 cycle, in the cycle after din changes 0->1 or 1->0.
REQ-015 When INP_DIS=1 or the state is not ACTIVE, the debouncer SHALL freeze: din holds its value, counter = 0, no edge pulses.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES SHALL never change din.
REQ-017 Counters SHALL saturate and never wrap; widths SHALL be 8 bits.

Reset
REQ-018 rst_n=0 SHALL immediately force state OFF and all counters to 0.
REQ-019 rst_n=0 SHALL immediately force DM=3'b001, INP_DIS=0, SLOW=0, OE_N=1, OUT=0, HLD_H_N=0, ENABLE_H=0, ENABLE_INP_H=0, din=0, din_rise=0, din_fall=0, ready=0, and shadow registers = {3'b001,0,0}.
REQ-020 Reset asserted mid-operation, including ACTIVE, SHALL override everything with no HOLD_DN sequence; release SHALL be synchronous to clk via the reset tree.

Verification
REQ-021 pad_en=1 at cycle 0, PWRUP_CYCLES=16 -> ENABLE_H=1 at cycle 1, HLD_H_N=1 at cycle 17, ready=1 at cycle 18.
REQ-022 In ACTIVE: cfg_we with cfg_dm=3'b110, then doe=1, dout=1 -> DM=3'b110 one cycle after the write, OE_N=0 and OUT=1 one cycle after the drive; pad_en=0 -> OE_N=1 and DM=3'b001 immediately on leaving ACTIVE, HLD_H_N=0, then ENABLE_H=0 two cycles later.
REQ-023 DEBOUNCE_CYCLES=4, IN high for 3 cycles then low -> din stays 0 with no pulses; IN high for 6 cycles -> din=1 and one din_rise pulse.
REQ-024 pad_en dropped at SETTLE count 5 -> OFF next cycle, HLD_H_N never 1; reasserting pad_en restarts the full 16-cycle count.
REQ-025 rst_n pulsed low in ACTIVE while driving -> all outputs equal the REQ-019 values in the same cycle; after release, pad_en=1 repeats the REQ-021 timing.
REQ-026 INP_DIS=1 written in ACTIVE, then IN toggled for 20 cycles -> din unchanged, no edge pulses.
